alu_div: RTL and testbench
==========================

Name: alu_div

Overview:
- Iterative 16-bit integer divider; the inverse operation of the ALU's combinational multiplier.
- Sits beside the ALU and is driven by the sequencer for DIV/REM instructions.
- Restoring division, one quotient bit per clock.
- Start/busy/done handshake; results are held until the next accepted start.

Parameters:
- WIDTH, 16, operand/result width in bits. The only supported value is 16; the test plan assumes it.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only when busy=0
- sgn  in  1  1 = two's-complement signed divide; 0 = unsigned. Latched with start.
- dividend  in  WIDTH  numerator; latched with start
- divisor  in  WIDTH  denominator; latched with start
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  WIDTH  result quotient
- remainder  out  WIDTH  result remainder
- div_zero  out  1  divisor was zero; valid with done, held
- ovf  out  1  signed overflow (0x8000 / 0xFFFF); valid with done, held

Behaviour:
- Reset: the synchronous reset is active-high and has priority over everything.
  - Next state = IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_zero=0, ovf=0.
  - Reset mid-RUN aborts the operation. No done pulse is generated.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: latch operands and sgn.
  - If divisor=0: go to DONE.
  - Otherwise: go to RUN with iteration count 0.
- Signed preparation, at accept: when sgn=1, work on the absolute values of both operands. Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend). |0x8000| is handled as the 17-bit-safe unsigned value 0x8000.
- RUN:
  - busy=1, done=0.
  - Each cycle: shift {partial remainder, working dividend} left by 1.
  - Trial subtract the divisor magnitude from the partial remainder, using a 17-bit subtract.
  - If the result is non-negative: keep the difference and set quotient bit = 1. Otherwise restore and set the bit = 0.
  - After WIDTH iterations (count = WIDTH-1 on the current cycle), go to DONE.
  - start is ignored while in RUN.
- DONE (one cycle):
  - busy=0, done=1.
  - quotient, remainder, div_zero and ovf update on the edge entering DONE.
  - Signed result: quotient is negated if neg_q; remainder is negated if neg_r. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: quotient=0xFFFF, remainder=original dividend, div_zero=1, ovf=0. This applies for both sgn values.
  - Signed 0x8000 / 0xFFFF: quotient=0x8000, remainder=0, ovf=1.
  - Otherwise div_zero=0 and ovf=0.
  - start=1 in the DONE cycle is accepted exactly as in IDLE (back-to-back operation). Without start, go to IDLE.
- Latency, with start sampled at the end of cycle 0:
  - Normal divide: busy in cycles 1..16, done in cycle 17.
  - Divide by zero: done in cycle 1 and busy never asserts.
- Output hold: outputs hold their last values in IDLE, RUN and DONE until the next DONE entry or reset. Outputs do not change during RUN.
- Operand stability: changes on dividend, divisor or sgn after accept have no effect.

Test Plan:
- Unsigned 1000/7: sgn=0, dividend=0x03E8, divisor=0x0007, start pulse at cycle 0 -> busy in cycles 1..16; done in cycle 17 with quotient=0x008E, remainder=0x0006, div_zero=0, ovf=0.
- Divide by zero: dividend=0x1234, divisor=0 -> done in cycle 1 with quotient=0xFFFF, remainder=0x1234, div_zero=1; busy never high.
- Signed -7/2 (0xFFF9/0x0002) -> quotient=0xFFFD, remainder=0xFFFF. Then 7/-2 (0x0007/0xFFFE) -> quotient=0xFFFD, remainder=0x0001.
- Signed overflow: sgn=1, 0x8000/0xFFFF -> quotient=0x8000, remainder=0, ovf=1. Same operands with sgn=0 -> quotient=0x0000, remainder=0x8000, ovf=0.
- Handshake:
  - start=1 with operands 5/0 at cycle 4 during RUN is ignored; the first result is unchanged.
  - start in the DONE cycle with 0xFFFF/0x0001 unsigned -> next done 17 cycles later with quotient=0xFFFF, remainder=0.
- Reset mid-operation: reset in cycle 8 of RUN -> next cycle busy=0, quotient=0, remainder=0; no done pulse for the aborted operation.

Source files
------------

// File: rtl/alu_div.sv
// alu_div: restoring divider, one quotient bit per clock; start/busy/done handshake, quotient/remainder/div_zero/ovf held until next result
module alu_div #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pr_q, pr_d, wd_q, wd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             nq_q, nq_d, nr_q, nr_d, ov_q, ov_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [WIDTH:0]   sh, diff;
  logic             ge;
  logic [WIDTH-1:0] q_raw, r_raw;
  always_comb begin
    sh    = {pr_q, wd_q[WIDTH-1]};
    diff  = sh - {1'b0, dvs_q};
    ge    = ~diff[WIDTH];
    q_raw = {wd_q[WIDTH-2:0], ge};
    r_raw = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    wd_d    = wd_q;
    dvs_d   = dvs_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    ov_d    = ov_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    if (state_q == RUN) begin
      pr_d  = r_raw;
      wd_d  = q_raw;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        quo_d   = nq_q ? -q_raw : q_raw;
        rem_d   = nr_q ? -r_raw : r_raw;
        dz_d    = 1'b0;
        ovf_d   = ov_q;
      end
    end else if (start) begin
      if (divisor == '0) begin
        state_d = DONE;
        quo_d   = '1;
        rem_d   = dividend;
        dz_d    = 1'b1;
        ovf_d   = 1'b0;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
        pr_d    = '0;
        wd_d    = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_d   = (sgn && divisor[WIDTH-1]) ? -divisor : divisor;
        nq_d    = sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        nr_d    = sgn && dividend[WIDTH-1];
        ov_d    = sgn && dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      wd_q    <= '0;
      dvs_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      ov_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      wd_q    <= wd_d;
      dvs_q   <= dvs_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      ov_q    <= ov_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div: randomized and directed checks of alu_div against an arithmetic reference model
module tb_alu_div;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, sgn = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        busy, done, div_zero, ovf;
  logic [15:0] quotient, remainder;
  int          vectors = 0, errors = 0;

  alu_div #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .sgn(sgn),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clock = ~clock;

  function automatic logic [33:0] model(input logic s, input logic [15:0] a, input logic [15:0] b);
    int x, y;
    logic [15:0] q, r;
    if (b == 16'h0) return {16'hFFFF, a, 1'b1, 1'b0};
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
      if (x == -32768 && y == -1) return {16'h8000, 16'h0000, 1'b0, 1'b1};
      q = 16'(x / y);
      r = 16'(x % y);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r, 1'b0, 1'b0};
  endfunction

  // Starts one divide from a negedge and returns at the negedge of its done cycle.
  // poke: cycle number during RUN at which a 5/0 start is thrown at the busy divider.
  // gap: also check that done drops and the unit idles on the following cycle.
  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input int poke, input bit gap, input string nm);
    logic [33:0] exp_v;
    logic [15:0] q0, r0;
    int          cyc;
    bit          bad_busy, moved;
    exp_v = model(s, a, b);
    sgn = s; dividend = a; divisor = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0; sgn = 1'($urandom); dividend = 16'($urandom); divisor = 16'($urandom);
    cyc = 1; bad_busy = 0; moved = 0; q0 = quotient; r0 = remainder;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== (b != 16'h0)) bad_busy = 1;
      if (quotient !== q0 || remainder !== r0) moved = 1;
      if (cyc == poke) begin
        start = 1'b1; dividend = 16'd5; divisor = 16'd0;
      end else start = 1'b0;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    vectors++;
    if (cyc !== (b == 16'h0 ? 1 : 17)) begin
      errors++; $display("FAIL %s latency: done in cycle %0d, expected %0d", nm, cyc, b == 16'h0 ? 1 : 17);
    end
    vectors++;
    if (bad_busy || busy !== 1'b0) begin
      errors++; $display("FAIL %s busy: wrong level during op (busy at done=%b)", nm, busy);
    end
    vectors++;
    if (moved) begin
      errors++; $display("FAIL %s hold: outputs changed during RUN", nm);
    end
    vectors++;
    if ({quotient, remainder, div_zero, ovf} !== exp_v) begin
      errors++;
      $display("FAIL %s result: got q=%h r=%h dz=%b ovf=%b, expected q=%h r=%h dz=%b ovf=%b",
               nm, quotient, remainder, div_zero, ovf, exp_v[33:18], exp_v[17:2], exp_v[1], exp_v[0]);
    end
    if (gap) begin
      @(negedge clock);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || {quotient, remainder, div_zero, ovf} !== exp_v) begin
        errors++; $display("FAIL %s after_done: done=%b busy=%b q=%h r=%h, expected 0 0 %h %h",
                           nm, done, busy, quotient, remainder, exp_v[33:18], exp_v[17:2]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; divisor = 16'h0;
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if ({busy, done, quotient, remainder, div_zero, ovf} !== 36'h0) begin
      errors++; $display("FAIL reset: got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, expected all 0",
                         busy, done, quotient, remainder, div_zero, ovf);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed();
    run_op(1'b0, 16'h03E8, 16'h0007, 0, 1, "unsigned_1000_7");
    run_op(1'b0, 16'h1234, 16'h0000, 0, 1, "div_zero_u");
    run_op(1'b1, 16'h8765, 16'h0000, 0, 1, "div_zero_s");
    run_op(1'b1, 16'hFFF9, 16'h0002, 0, 1, "signed_m7_2");
    run_op(1'b1, 16'h0007, 16'hFFFE, 0, 1, "signed_7_m2");
    run_op(1'b1, 16'h8000, 16'hFFFF, 0, 1, "signed_ovf");
    run_op(1'b0, 16'h8000, 16'hFFFF, 0, 1, "unsigned_8000_ffff");
    run_op(1'b1, 16'h8000, 16'h0001, 0, 1, "signed_min_1");
  endtask

  task automatic test_ignore_start();
    run_op(1'b0, 16'h03E8, 16'h0007, 4, 1, "ignore_start");
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 16'h03E8, 16'h0007, 0, 0, "b2b_first");
    run_op(1'b0, 16'hFFFF, 16'h0001, 0, 0, "b2b_second");
    run_op(1'b0, 16'h4321, 16'h0000, 0, 0, "b2b_zero");
    run_op(1'b1, 16'hFFF9, 16'h0002, 0, 1, "b2b_signed");
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    sgn = 1'b0; dividend = 16'h03E8; divisor = 16'h0007; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if ({busy, done, quotient, remainder, div_zero, ovf} !== 36'h0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h, expected all 0",
                         busy, done, quotient, remainder);
    end
    saw_done = 0;
    repeat (25) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
    end
    vectors++;
    if (saw_done) begin
      errors++; $display("FAIL reset_mid_abort: activity after aborted op, expected none");
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic        s;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: b = 16'h0000;
        1: b = 16'hFFFF;
        2: b = 16'($urandom_range(1, 15));
        3: a = 16'h8000;
        default: ;
      endcase
      run_op(s, a, b, 0, 1'($urandom), $sformatf("random_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
